// File: rtl/mul_normalizer_pipe.sv
// Two-stage normaliser for PE multiplier products: S1 aligns the 1x/2x product, S2 rounds and
// resolves overflow/underflow/zero before packing {sign, exponent, mantissa} for the accumulator.
module mul_normalizer_pipe #(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int ROUND_EN = 1,
  parameter int TAG_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sign,
  input  logic signed [EXP_W+1:0]       in_exp,
  input  logic [2*(MAN_W+1)-1:0]        in_prod,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_W+MAN_W:0]          out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_ovf,
  output logic                          out_unf,
  output logic                          out_inexact
);

  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int EW     = EXP_W + 2;
  localparam int RES_W  = 1 + EXP_W + MAN_W;

  // S2 exponent carries one spare bit so the rounding increment cannot wrap
  localparam logic signed [EW:0] EXP_MAX  = (EW+1)'((1 << EXP_W) - 1);
  localparam logic signed [EW:0] EXP_ZERO = '0;

  logic                 s2_adv;
  logic                 s1_adv;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W-1:0]     s1_man_q, s1_man_d;
  logic                 s1_g_q, s1_g_d;
  logic                 s1_s_q, s1_s_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [RES_W-1:0]     s2_result_q, s2_result_d;
  logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;
  logic                 s2_ovf_q, s2_ovf_d;
  logic                 s2_unf_q, s2_unf_d;
  logic                 s2_inexact_q, s2_inexact_d;

  logic [MAN_W-1:0]     nrm_man;
  logic                 nrm_g;
  logic                 nrm_s;
  logic                 nrm_zero;
  logic signed [EW-1:0] nrm_exp;

  logic                 rnd_up;
  logic                 rnd_carry;
  logic [MAN_W-1:0]     rnd_man;
  logic signed [EW:0]   rnd_exp;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  always_comb begin
    nrm_man  = '0;
    nrm_g    = 1'b0;
    nrm_s    = 1'b0;
    nrm_zero = 1'b0;
    nrm_exp  = in_exp;
    if (in_prod[PROD_W-1]) begin
      nrm_man = in_prod[PROD_W-2 -: MAN_W];
      nrm_g   = in_prod[PROD_W-2-MAN_W];
      nrm_s   = |in_prod[PROD_W-3-MAN_W:0];
      nrm_exp = in_exp + EW'(1);
    end else if (in_prod[PROD_W-2]) begin
      nrm_man = in_prod[PROD_W-3 -: MAN_W];
      nrm_g   = in_prod[PROD_W-3-MAN_W];
      nrm_s   = |in_prod[PROD_W-4-MAN_W:0];
    end else begin
      nrm_zero = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_zero_d  = s1_zero_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = nrm_exp;
        s1_man_d  = nrm_man;
        s1_g_d    = nrm_g;
        s1_s_d    = nrm_s;
        s1_zero_d = nrm_zero;
        s1_tag_d  = in_tag;
      end
    end
  end

  always_comb begin
    rnd_up               = (ROUND_EN != 0) && s1_g_q && (s1_s_q || s1_man_q[0]);
    {rnd_carry, rnd_man} = {1'b0, s1_man_q} + {{MAN_W{1'b0}}, rnd_up};
    rnd_exp              = $signed({s1_exp_q[EW-1], s1_exp_q}) + $signed({{EW{1'b0}}, rnd_carry});
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_ovf_d     = s2_ovf_q;
    s2_unf_d     = s2_unf_q;
    s2_inexact_d = s2_inexact_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_tag_d     = s1_tag_q;
        s2_ovf_d     = 1'b0;
        s2_unf_d     = 1'b0;
        s2_inexact_d = s1_g_q || s1_s_q;
        if (s1_zero_q) begin
          s2_result_d  = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
          s2_inexact_d = 1'b0;
        end else if (rnd_exp >= EXP_MAX) begin
          s2_result_d  = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          s2_ovf_d     = 1'b1;
          s2_inexact_d = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
          s2_result_d  = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
          s2_unf_d     = 1'b1;
          s2_inexact_d = 1'b1;
        end else begin
          s2_result_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_man};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_man_q     <= '0;
      s1_g_q       <= 1'b0;
      s1_s_q       <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_ovf_q     <= 1'b0;
      s2_unf_q     <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_man_q     <= s1_man_d;
      s1_g_q       <= s1_g_d;
      s1_s_q       <= s1_s_d;
      s1_zero_q    <= s1_zero_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_unf_q     <= s2_unf_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  always_comb begin
    out_valid   = s2_valid_q;
    out_result  = s2_result_q;
    out_tag     = s2_tag_q;
    out_ovf     = s2_ovf_q;
    out_unf     = s2_unf_q;
    out_inexact = s2_inexact_q;
  end

endmodule

// File: tb/tb_mul_normalizer_pipe.sv
// Scoreboard bench for mul_normalizer_pipe: a rounding instance and a truncating instance share
// stimulus; expected values come from a behavioural model of the normalise/round/exception rules.
module tb_mul_normalizer_pipe;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready, t_in_ready;
  logic              in_sign = 1'b0;
  logic signed [6:0] in_exp = '0;
  logic [21:0]       in_prod = '0;
  logic [3:0]        in_tag = '0;
  logic              out_ready = 1'b1;
  logic              out_valid, t_out_valid;
  logic [15:0]       out_result, t_out_result;
  logic [3:0]        out_tag, t_out_tag;
  logic              out_ovf, t_out_ovf;
  logic              out_unf, t_out_unf;
  logic              out_inexact, t_out_inexact;

  typedef struct {
    logic [3:0]  tag;
    logic [18:0] rne;
    logic [18:0] trn;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   accepted = 0;
  int   pops = 0;
  bit   rnd_done;

  mul_normalizer_pipe #(.EXP_W(5), .MAN_W(10), .ROUND_EN(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_prod(in_prod), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_ovf(out_ovf),
    .out_unf(out_unf), .out_inexact(out_inexact));

  mul_normalizer_pipe #(.EXP_W(5), .MAN_W(10), .ROUND_EN(0), .TAG_W(4)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_prod(in_prod), .in_tag(in_tag), .out_valid(t_out_valid),
    .out_ready(out_ready), .out_result(t_out_result), .out_tag(t_out_tag), .out_ovf(t_out_ovf),
    .out_unf(t_out_unf), .out_inexact(t_out_inexact));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns {ovf, unf, inexact, result[15:0]}
  function automatic logic [18:0] model(input logic sg, input int ex, input logic [21:0] pr,
                                        input bit rnd);
    int man, e;
    bit g, s, inx;
    logic [4:0] ef;
    if (pr[21]) begin
      man = int'(pr[20:11]); g = pr[10]; s = (pr[9:0] != 0); e = ex + 1;
    end else if (pr[20]) begin
      man = int'(pr[19:10]); g = pr[9]; s = (pr[8:0] != 0); e = ex;
    end else begin
      return {3'b000, sg, 15'h0};
    end
    if (rnd && g && (s || (man % 2 == 1))) begin
      man = man + 1;
      if (man == 1024) begin
        man = 0;
        e = e + 1;
      end
    end
    inx = g | s;
    if (e >= 31) return {3'b101, sg, 5'h1f, 10'h0};
    if (e <= 0) return {3'b011, sg, 15'h0};
    ef = e[4:0];
    return {2'b00, inx, sg, ef, man[9:0]};
  endfunction

  task automatic send(input logic sg, input int ex, input logic [21:0] pr, input logic [3:0] tg);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_sign = sg; in_exp = 7'(ex); in_prod = pr; in_tag = tg;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.tag = tg;
      e.rne = model(sg, ex, pr, 1'b1);
      e.trn = model(sg, ex, pr, 1'b0);
      sb.push_back(e);
      accepted++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      check("trn_valid", 32'(t_out_valid), 32'(out_valid));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          check("rne_out", {9'h0, out_tag, out_ovf, out_unf, out_inexact, out_result},
                {9'h0, sb[0].tag, sb[0].rne});
          check("trn_out", {9'h0, t_out_tag, t_out_ovf, t_out_unf, t_out_inexact, t_out_result},
                {9'h0, sb[0].tag, sb[0].trn});
          if (out_ready) begin
            void'(sb.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0;
    #12 rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outs", {10'h0, out_valid, out_ovf, out_unf, out_inexact, out_tag, out_result},
          32'h0);

    // directed: basic, rounding carry, ties to even, exceptions
    send(1'b0, 15, 22'h240000, 4'h1);
    send(1'b0, 15, 22'h1FFFFF, 4'h2);
    send(1'b0, 15, 22'h100200, 4'h3);
    send(1'b0, 15, 22'h100600, 4'h4);
    send(1'b1, 30, 22'h200000, 4'h5);
    send(1'b0, 0,  22'h100000, 4'h6);
    send(1'b0, -3, 22'h100000, 4'h7);
    send(1'b0, 15, 22'h000000, 4'h8);
    send(1'b1, 29, 22'h3FFFFF, 4'h9);
    wait_empty();

    // backpressure: 5 beats against a stalled output
    @(negedge clk);
    out_ready = 1'b0;
    a0 = accepted;
    fork
      begin
        for (int i = 0; i < 5; i++) send(i[0], 10 + i, 22'h180000 + 22'(i * 37), 4'(i + 1));
      end
      begin
        repeat (8) @(negedge clk);
        #2;
        check("stall_accepted", 32'(accepted - a0), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        p0 = pops;
        repeat (5) @(negedge clk);
        #4;
        check("drain_rate", 32'(pops - p0), 32'd5);
      end
    join
    wait_empty();

    // reset with two beats in flight
    send(1'b0, 12, 22'h300000, 4'hA);
    send(1'b1, 13, 22'h1C0000, 4'hB);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {10'h0, out_valid, out_ovf, out_unf, out_inexact, out_tag, out_result},
          32'h0);
    check("rst_mid_trn_valid", 32'(t_out_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 16, 22'h2A0000, 4'hC);
    @(negedge clk); #3;
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk); #3;
    check("lat_cycle2", 32'(out_valid), 32'd1);
    wait_empty();

    // random stream with random output stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [21:0] pr;
          pr = 22'($urandom);
          if ($urandom_range(0, 3) == 0) pr[21] = 1'b0;
          if ($urandom_range(0, 7) == 0) pr[21:20] = 2'b00;
          send(1'($urandom), int'($urandom_range(0, 45)) - 8, pr, 4'(i));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_normalizer_pipe.md
Name: mul_normalizer_pipe

Overview:
Parametrised, pipelined successor to the combinational multiplier normalizer. It takes the raw mantissa product and pre-adjusted exponent from a systolic PE multiplier and normalises the 1x/2x product. It applies round-to-nearest-even (or legacy truncation), detects overflow, underflow and zero, and packs a sign/exponent/mantissa result. It sits between the PE multiplier array and the accumulator, with a valid/ready handshake and a sideband tag.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa width (hidden bit excluded); PROD_W = 2*(MAN_W+1) derived locally
ROUND_EN, 1, 1 = round-to-nearest-even, 0 = truncate (legacy behaviour)
TAG_W, 4, width of passthrough sideband tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input this cycle
in_sign  in  1  product sign (passthrough)
in_exp  in  EXP_W+2  signed two's-complement biased exponent sum, before normalisation
in_prod  in  PROD_W  unsigned mantissa product, hidden bits included
in_tag  in  TAG_W  sideband tag (passthrough)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  1+EXP_W+MAN_W  {sign, exponent, mantissa}
out_tag  out  TAG_W  tag aligned with out_result
out_ovf  out  1  overflow: result forced to infinity
out_unf  out  1  underflow: result flushed to zero
out_inexact  out  1  discarded bits were nonzero

Behaviour:
- Reset (async assert, sync release): both stage valids = 0; all output data/flag registers = 0. in_ready = 1 from the first cycle after reset.
- Pipeline: two register stages (S1, S2). Latency is 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational).
  - While out_valid & !out_ready, out_result/out_tag/flags are held stable.
  - No beat is dropped or duplicated. Order is preserved.
- S1 (normalise):
  - If in_prod[PROD_W-1] = 1: man = in_prod[PROD_W-2 -: MAN_W]; G = next lower bit; S = OR of remaining bits; e = in_exp + 1.
  - Else if in_prod[PROD_W-2] = 1: man = in_prod[PROD_W-3 -: MAN_W]; G and S taken the same way; e = in_exp.
  - Else (zero or subnormal operand): zero flag set.
  - e is computed at EXP_W+2 bits signed. Sign and tag are registered.
- S2 (round + exceptions):
  - ROUND_EN = 1: round up when G & (S | man[0]).
  - Rounding carry out of man (all ones + 1) gives man = 0, e = e + 1.
  - ROUND_EN = 0: man unchanged.
  - inexact = G | S in both modes.
  - Priority: zero -> result {sign, 0, 0}, no flags. Else e >= 2^EXP_W - 1 -> {sign, all-ones, 0}, ovf = 1. Else e <= 0 -> {sign, 0, 0}, unf = 1. Else {sign, e[EXP_W-1:0], man}.
  - ovf and unf are never set together. inexact is forced to 0 for a zero input and forced to 1 on ovf or unf.
- No denormal output and no NaN generation; upstream handles NaN operands.
- Reset mid-operation discards all in-flight beats. No output is produced for them.

Test Plan:
1. Defaults, ROUND_EN = 1. in_exp = 15, in_prod = 0x240000 (1.5 x 1.5), sign 0 -> two cycles later out_result = 0x4080; ovf, unf, inexact all 0; tag echoed.
2. Rounding carry. in_exp = 15, in_prod = 0x1FFFFF -> 0x4000, inexact = 1. Same stimulus with ROUND_EN = 0 -> 0x3FFF, inexact = 1.
3. Ties to even.
   - in_prod = 0x100200, in_exp = 15 -> 0x3C00, inexact = 1.
   - in_prod = 0x100600 -> 0x3C02.
4. Exceptions.
   - in_exp = 30, in_prod = 0x200000, sign 1 -> 0xFC00, ovf = 1.
   - in_exp = 0, in_prod = 0x100000 -> 0x0000, unf = 1.
   - in_exp = -3, in_prod = 0x100000 -> 0x0000, unf = 1.
   - in_prod = 0 -> 0x0000, no flags.
5. Backpressure. Stream 5 tagged beats with out_ready = 0.
   - in_ready drops after 2 beats accepted.
   - Output is held stable across the stall.
   - After releasing out_ready, all 5 beats emerge in tag order, one per cycle, with correct values.
6. Reset. Assert rst_n low with 2 beats in flight -> out_valid = 0 immediately, outputs 0. After release, a new beat completes normally with latency 2.
